// File: rtl/apb_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// APB request arbiter.
package apb_arb_pkg;

   // Largest supported requester count; rr_pick works on this fixed width.
   localparam int MAX_REQ     = 8;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   // Returns the one-hot winner: the first set bit of req at or after ptr,
   // searching upward and wrapping from nreq-1 back to 0.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 nreq);
      logic [MAX_REQ-1:0] win;
      logic               found;
      logic [3:0]         idx;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         // ptr < nreq and i < nreq, so one subtraction is enough to wrap.
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= 4'(nreq)) idx = idx - 4'(nreq);
         if (i < nreq && !found && req[idx[2:0]]) begin
            win[idx[2:0]] = 1'b1;
            found         = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Command port between the arbiter (master) and the APB bridge (slave).
interface apb_req_arbiter_if
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              start;
   logic              wr;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              done;

   modport master (output start, wr, address, data_in, input data_out, done);
   modport slave  (input start, wr, address, data_in, output data_out, done);
endinterface

// File: rtl/apb_rr_arbiter.sv
// Pure combinational round-robin picker: one-hot winner plus its index.
module apb_rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int  NREQ  = DEF_NREQ,
   localparam int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt_oh,
   output logic [PTR_W-1:0] gnt_idx
);

   logic [MAX_REQ-1:0] pick;

   // Pick the winner and encode its position.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      pick    = rr_pick(MAX_REQ'(req), 3'(ptr), NREQ);
      gnt_oh  = pick[NREQ-1:0];
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) gnt_idx = PTR_W'(i);
      end
   end

   // Bits above NREQ are always zero because req is zero-extended.
   wire unused_pick = ^pick;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB bridge command port among
// NREQ requesters. Optional WAIT timeout: define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   apb_req_arbiter_if.master      bridge
);

   localparam int PTR_W = $clog2(NREQ);

   arb_state_e        state;
   logic [PTR_W-1:0]  ptr;
   logic [NREQ-1:0]   pick_oh;
   logic [PTR_W-1:0]  pick_idx;
   logic              start_q;
   logic              wr_q;
   logic [ADDR_W-1:0] address_q;
   logic [DATA_W-1:0] data_in_q;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0]  wait_cnt;
   logic              rsp_err_q;
`endif

   apb_rr_arbiter #(.NREQ(NREQ)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx)
   );

   // Arbitration FSM with registered command and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         start_q   <= 1'b0;
         wr_q      <= 1'b0;
         address_q <= '0;
         data_in_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         wait_cnt  <= '0;
         rsp_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         start_q   <= 1'b0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= pick_oh;
                  wr_q      <= req_wr[pick_idx];
                  address_q <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                  data_in_q <= req_wdata[pick_idx*DATA_W +: DATA_W];
                  ptr       <= (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  start_q   <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef APB_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state    <= WAIT;
            end
            WAIT: begin
               if (bridge.done) begin
                  rsp_valid <= gnt;
                  rsp_rdata <= bridge.data_out;
`ifdef APB_ARB_TIMEOUT_EN
                  rsp_err_q <= 1'b0;
`endif
                  state     <= RESP;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                  rsp_valid <= gnt;
                  rsp_rdata <= '0;
                  rsp_err_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               gnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bridge.start   = start_q;
   assign bridge.wr      = wr_q;
   assign bridge.address = address_q;
   assign bridge.data_in = data_in_q;

`ifdef APB_ARB_TIMEOUT_EN
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
   localparam int unused_timeout = TIMEOUT;
`endif

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares one APB bridge transaction port among NREQ independent requesters. It selects one pending request and latches its command. It then drives the bridge's start/wr/address/data_in, waits for bridge completion and returns read data and status to the granted requester. It sits directly in front of the bridge's command port, with the bridge's master/slave pair behind it.

## Interface
- NREQ, 4: number of requesters, 2..8
- ADDR_W, 32: address width
- DATA_W, 32: data width
- TIMEOUT, 255: WAIT-cycle limit, used only with APB_ARB_TIMEOUT_EN
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until the matching rsp_valid
- req_wr  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data, same packing
- gnt  out  NREQ  one-hot grant, registered
- rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; last value held otherwise
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid
- start  out  1  one-cycle command pulse to the bridge
- wr  out  1  latched direction to the bridge
- address  out  ADDR_W  latched address to the bridge
- data_in  out  DATA_W  latched write data to the bridge
- data_out  in  DATA_W  bridge read data
- done  in  1  bridge completion pulse; data_out is valid in the same cycle

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP; the reset state is IDLE.
- **IDLE**
  - Does nothing while req == 0.
  - Otherwise picks the first set bit at or after pointer ptr, searching circularly upward with wrap NREQ-1 -> 0.
  - Registers gnt, wr, address and data_in from the winner's slices, then moves to ISSUE.
  - Sets ptr to winner+1 mod NREQ.
- **ISSUE**
  - Holds start = 1 for exactly one cycle, then moves to WAIT.
- **WAIT**
  - Holds all bridge outputs stable with start = 0.
  - On done: captures data_out into rsp_rdata, clears the error, and moves to RESP.
- **RESP**
  - Pulses rsp_valid[winner] for one cycle, clears gnt, and returns to IDLE.
- Only one transaction is outstanding at a time. Requests arriving or dropping outside IDLE are ignored until the next arbitration.
- A done received outside WAIT is ignored; no spurious response is generated.
- Requester inputs are not re-sampled after IDLE, so later changes cannot corrupt the in-flight command.
- Reset mid-transaction returns the block to IDLE immediately:
  - start, gnt, rsp_valid and rsp_err go to 0.
  - ptr goes to 0.
  - The in-flight transaction is dropped with no response.
- Reset values of all other outputs:
  - wr = 0, address = 0, data_in = 0, rsp_rdata = 0.

## Timing
- Uncontended latency, with req seen in IDLE at cycle T:
  - gnt and command registers at T+1, start = 1 in cycle T+1 (ISSUE).
  - With done at cycle D, rsp_valid = 1 in cycle D+1.
- Back-to-back: the next arbitration happens at D+2, so the next start is at D+3 at the earliest.
- Every output is registered; there is no combinational path from any input to any output.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,…,NREQ-1,0. The maximum wait is NREQ-1 transactions.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter counts cycles in WAIT.
  - If TIMEOUT cycles elapse without done, the FSM moves to RESP with rsp_err = 1 and rsp_rdata = 0.
  - A done arriving in the same cycle as the limit wins, giving a normal completion.
  - A late done arriving after abort is ignored by the rule above.
- Not defined: no counter, rsp_err is tied to 0, and WAIT waits indefinitely.

## Structure
- Package apb_arb_pkg holds the following:
  - State enum arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Default width and count localparams.
  - Function rr_pick(req, ptr), returning the one-hot winner.
- One sub-module, apb_rr_arbiter: a pure combinational round-robin picker whose inputs are req and ptr and whose outputs are a one-hot grant and its index.
- The top module holds the FSM, the command and response registers and the optional timeout counter.

## Test plan
- Single write:
  - Stimulus: req=0001, wr=1, addr0=0x10, wdata0=0xDEADBEEF; done 3 cycles after start.
  - Required: start pulses once with address=0x10 and data_in=0xDEADBEEF; rsp_valid=0001 exactly one cycle after done; rsp_err=0.
- Single read:
  - Stimulus: req=0100, addr2=0x24; data_out=0x12345678 with done.
  - Required: rsp_rdata=0x12345678 with rsp_valid=0100.
- Rotation:
  - Stimulus: req=1111 held, with each requester re-asserting after its response.
  - Required: grant order 0,1,2,3,0,1 and exactly one start per grant.
- Wrap and skip:
  - Stimulus: ptr=3 (after a grant to 2) with req=0011.
  - Required: grant 0, then grant 1; requester 3 is never granted.
- Reset mid-WAIT:
  - Stimulus: assert rst_n=0 during WAIT, then release.
  - Required: all outputs at their reset values; no rsp_valid; the next req=0010 is granted to requester 1 normally.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: done never asserted.
  - Required: rsp_valid with rsp_err=1 and rsp_rdata=0, 8 cycles after WAIT entry plus 1; a later stray done produces no response.
